count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Control stage directly upstream of the team's clear/increment counter.
- Drives the counter's clr and inc inputs and reads back its count output.
- Runs a programmable counting job: clear the counter, pace increments with a prescaler, and stop exactly at a target value.
- Supports pause/resume and abort; reports busy and a done pulse to the host/control logic.

Parameters:
- WIDTH, 8, counter width; must equal the downstream counter's WIDTH.
- PRESCALE_W, 8, width of the period field and internal prescaler.

Ports:
- aclk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- start  in  1  begin a job from IDLE; resume from PAUSE.
- stop  in  1  pause a running job.
- abort  in  1  cancel the job from any state.
- period  in  PRESCALE_W  inc issued once every period+1 RUN cycles; sampled on job start.
- target  in  WIDTH  final count value; sampled on job start.
- count  in  WIDTH  counter output, fed back.
- clr  out  1  to counter clr.
- inc  out  1  to counter inc.
- busy  out  1  high in CLEAR, RUN, PAUSE.
- done  out  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset: state=IDLE, prescaler=0, period_q=0, target_q=0; clr=inc=busy=done=0.
- Input priority each cycle: abort > stop > start.
- States:
  - IDLE: on start, latch period_q/target_q and go to CLEAR.
  - CLEAR: one cycle, clr=1, prescaler<=0, then RUN. abort -> IDLE (clr still 1 this cycle).
  - RUN:
    - If count==target_q -> DONE; no inc this cycle.
    - Else if stop -> PAUSE; prescaler holds; no inc.
    - Else if prescaler==period_q: inc=1, prescaler<=0.
    - Else prescaler<=prescaler+1.
  - PAUSE: prescaler holds, inc=0. start -> RUN, resuming the prescaler value; stop and start both high -> stay in PAUSE.
  - DONE: one cycle, done=1, then IDLE. start ignored in DONE.
  - abort in any non-IDLE state -> IDLE next edge; inc=0 in the abort cycle; no clr issued on abort.
- Output decoding:
  - clr, busy, done are Moore outputs decoded from the state register.
  - inc is Mealy: RUN && prescaler==period_q && count!=target_q && !stop && !abort.
- The counter samples inc at the same edge, so count is updated one cycle after inc; the Mealy check prevents overshoot.
- period=0: inc every RUN cycle until target.
- target=0: RUN sees count==0 on its first cycle -> DONE, zero incs.
- target=2^WIDTH-1: legal; no wrap occurs because inc is suppressed on equality.
- Only equality is checked. An external clr/inc on the counter can make count miss target; the job then runs until count wraps to target or until abort.
- period and target changes mid-job have no effect.
- Reset mid-job returns to IDLE immediately; all outputs drop.

Decomposition:
- Shared package holds the state encoding localparams (IDLE, CLEAR, RUN, PAUSE, DONE; 3-bit) and the priority rule constants.
- One natural sub-module, count_prescaler: load/hold/terminal-compare counter of PRESCALE_W bits with a match output.
- The FSM and output decode stay in count_sequencer.

Test Plan (the bench instantiates the sequencer and the counter together; start pulsed in cycle 0):
- period=0, target=3:
  - CLEAR in cycle 1; inc high in cycles 2,3,4; count=3 in cycle 5.
  - done high in cycle 6; IDLE in cycle 7; exactly 3 inc pulses.
- period=2, target=2:
  - inc only in cycles 4 and 7; count=2 in cycle 8.
  - done in cycle 9; busy high in cycles 1-8.
- target=0, period=5:
  - clr in cycle 1; zero inc pulses; done in cycle 3.
- Pause/resume, period=0, target=5:
  - stop in cycle 3 (inc low that cycle); PAUSE in cycles 4-6; count holds at 1.
  - start in cycle 6; resume gives total inc pulses=5; done asserted once.
- Abort:
  - abort in cycle 4 of a target=10 job -> IDLE in cycle 5.
  - count holds at its value, busy=0, done never pulses.
  - A new start then issues clr first.
- Reset and priority:
  - arstn low mid-RUN -> all outputs 0 asynchronously.
  - start+stop+abort together in RUN -> IDLE.
  - start+stop together in PAUSE -> stays in PAUSE.

Source files
------------

// File: rtl/count_sequencer_pkg.sv
// Shared types for the count sequencer: FSM state encoding and the
// abort > stop > start command priority rule.
package count_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_ABORT = 2'd3
  } cmd_e;

  // Collapses the three host controls into the single command that wins this cycle.
  function automatic cmd_e resolve_cmd(input logic start, input logic stop, input logic abort);
    if (abort)     return CMD_ABORT;
    else if (stop) return CMD_STOP;
    else if (start) return CMD_START;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Prescaler for the count sequencer: clears to zero, holds, or advances and
// wraps to zero when it reaches the programmed period.
module count_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  match
);

  logic [PRESCALE_W-1:0] cnt;

  assign match = (cnt == period);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= match ? '0 : cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Control stage that drives a clear/increment counter through one job:
// clear, paced increments, and a stop exactly at the latched target.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  abort,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [WIDTH-1:0]      target,
  input  logic [WIDTH-1:0]      count,
  output logic                  clr,
  output logic                  inc,
  output logic                  busy,
  output logic                  done
);

  state_e                state;
  state_e                state_next;
  cmd_e                  cmd;
  logic [PRESCALE_W-1:0] period_q;
  logic [WIDTH-1:0]      target_q;
  logic                  load;
  logic                  at_target;
  logic                  pre_clear;
  logic                  pre_advance;
  logic                  pre_match;

  assign cmd       = resolve_cmd(start, stop, abort);
  assign at_target = (count == target_q);

  count_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (aclk),
    .rst_n  (arstn),
    .clear  (pre_clear),
    .advance(pre_advance),
    .period (period_q),
    .match  (pre_match)
  );

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state    <= ST_IDLE;
      period_q <= '0;
      target_q <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        period_q <= period;
        target_q <= target;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    pre_clear   = 1'b0;
    pre_advance = 1'b0;
    inc         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd == CMD_START) begin
          load       = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        pre_clear  = 1'b1;
        state_next = (cmd == CMD_ABORT) ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // Equality is checked before stop so a finished job never parks in PAUSE.
        if (cmd == CMD_ABORT) begin
          state_next = ST_IDLE;
        end else if (at_target) begin
          state_next = ST_DONE;
        end else if (cmd == CMD_STOP) begin
          state_next = ST_PAUSE;
        end else begin
          pre_advance = 1'b1;
          inc         = pre_match;
        end
      end
      ST_PAUSE: begin
        // start+stop together resolves to CMD_STOP and keeps the job parked.
        if (cmd == CMD_ABORT) begin
          state_next = ST_IDLE;
        end else if (cmd == CMD_START) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign clr  = (state == ST_CLEAR);
  assign busy = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_PAUSE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer wired to a clear/increment counter: per-cycle
// expected outputs and per-job increment totals are queued and checked by a monitor.
module tb_count_sequencer;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 8;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } exp_t;

  logic                  aclk = 1'b0;
  logic                  arstn;
  logic                  start;
  logic                  stop;
  logic                  abort;
  logic [PRESCALE_W-1:0] period;
  logic [WIDTH-1:0]      target;
  logic [WIDTH-1:0]      count;
  logic                  clr;
  logic                  inc;
  logic                  busy;
  logic                  done;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  int    job_q[$];
  int    inc_run = 0;
  string cur_tag = "none";
  int    cur_cyc = 0;

  always #5 aclk = ~aclk;

  count_sequencer #(
    .WIDTH     (WIDTH),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .aclk  (aclk),
    .arstn (arstn),
    .start (start),
    .stop  (stop),
    .abort (abort),
    .period(period),
    .target(target),
    .count (count),
    .clr   (clr),
    .inc   (inc),
    .busy  (busy),
    .done  (done)
  );

  // Downstream clear/increment counter.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic begin_job(input string tag, input int p, input int t, input int exp_incs);
    cur_tag = tag;
    cur_cyc = 0;
    period  = PRESCALE_W'(p);
    target  = WIDTH'(t);
    if (exp_incs >= 0) job_q.push_back(exp_incs);
  endtask

  // One clock cycle of stimulus plus the expected {clr,inc,busy,done,count} for that cycle.
  task automatic cyc(input bit s, input bit p, input bit a,
                     input bit ec, input bit ei, input bit eb, input bit ed,
                     input int en);
    exp_t e;
    @(posedge aclk);
    #1;
    start  = s;
    stop   = p;
    abort  = a;
    e.name = $sformatf("%s_c%0d", cur_tag, cur_cyc);
    e.exp  = {ec, ei, eb, ed, 8'(en)};
    exp_q.push_back(e);
    cur_cyc++;
  endtask

  task automatic idle(input int n, input int en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, en);
  endtask

  task automatic release_reset();
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    #1;
    arstn = 1'b1;
  endtask

  // Monitor: per-cycle output vectors, plus increment totals on each done pulse.
  always @(negedge aclk) begin
    exp_t e;
    if (!arstn) begin
      inc_run = 0;
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, 32'({clr, inc, busy, done, count}), 32'(e.exp));
      end
      if (clr)      inc_run = 0;
      else if (inc) inc_run++;
      if (done) begin
        if (job_q.size() == 0) check("done_unexpected", 32'(job_q.size()), 32'd1);
        else                   check("job_inc_total", 32'(inc_run), 32'(job_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    arstn  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    abort  = 1'b0;
    period = '0;
    target = '0;
    #2;
    check("reset_outputs", 32'({clr, inc, busy, done}), 32'd0);
    release_reset();
    begin_job("idle", 0, 0, -1);
    idle(2, 0);

    // period=0, target=3: inc in cycles 2..4, done in 6.
    begin_job("p0t3", 0, 3, 3);
    cyc(1,0,0, 0,0,0,0, 0);
    cyc(0,0,0, 1,0,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 1);
    cyc(0,0,0, 0,1,1,0, 2);
    cyc(0,0,0, 0,0,1,0, 3);
    cyc(0,0,0, 0,0,0,1, 3);
    cyc(0,0,0, 0,0,0,0, 3);

    // period=2, target=2: inc in cycles 4 and 7; mid-job input changes are ignored.
    begin_job("p2t2", 2, 2, 2);
    cyc(1,0,0, 0,0,0,0, 3);
    cyc(0,0,0, 1,0,1,0, 3);
    cyc(0,0,0, 0,0,1,0, 0);
    period = 8'd0;
    target = 8'd7;
    cyc(0,0,0, 0,0,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,0,1,0, 1);
    cyc(0,0,0, 0,0,1,0, 1);
    cyc(0,0,0, 0,1,1,0, 1);
    cyc(0,0,0, 0,0,1,0, 2);
    cyc(0,0,0, 0,0,0,1, 2);
    cyc(0,0,0, 0,0,0,0, 2);

    // target=0: clear then straight to done, no increments.
    begin_job("p5t0", 5, 0, 0);
    cyc(1,0,0, 0,0,0,0, 2);
    cyc(0,0,0, 1,0,1,0, 2);
    cyc(0,0,0, 0,0,1,0, 0);
    cyc(0,0,0, 0,0,0,1, 0);
    cyc(0,0,0, 0,0,0,0, 0);

    // Pause in cycle 3, start+stop in PAUSE stays parked, resume in cycle 6.
    begin_job("pause", 0, 5, 5);
    cyc(1,0,0, 0,0,0,0, 0);
    cyc(0,0,0, 1,0,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,1,0, 0,0,1,0, 1);
    cyc(0,0,0, 0,0,1,0, 1);
    cyc(1,1,0, 0,0,1,0, 1);
    cyc(1,0,0, 0,0,1,0, 1);
    cyc(0,0,0, 0,1,1,0, 1);
    cyc(0,0,0, 0,1,1,0, 2);
    cyc(0,0,0, 0,1,1,0, 3);
    cyc(0,0,0, 0,1,1,0, 4);
    cyc(0,0,0, 0,0,1,0, 5);
    cyc(0,0,0, 0,0,0,1, 5);
    cyc(0,0,0, 0,0,0,0, 5);

    // Abort in cycle 4: back to IDLE, count holds, no done.
    begin_job("abort", 0, 10, -1);
    cyc(1,0,0, 0,0,0,0, 5);
    cyc(0,0,0, 1,0,1,0, 5);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 1);
    cyc(0,0,1, 0,0,1,0, 2);
    cyc(0,0,0, 0,0,0,0, 2);
    cyc(0,0,0, 0,0,0,0, 2);

    // Restart clears first; start+stop+abort together in RUN aborts.
    begin_job("prio", 0, 10, -1);
    cyc(1,0,0, 0,0,0,0, 2);
    cyc(0,0,0, 1,0,1,0, 2);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 1);
    cyc(1,1,1, 0,0,1,0, 2);
    cyc(0,0,0, 0,0,0,0, 2);
    cyc(0,0,0, 0,0,0,0, 2);

    // Reset asserted mid-RUN drops every output without a clock edge.
    begin_job("rstrun", 0, 200, -1);
    cyc(1,0,0, 0,0,0,0, 2);
    cyc(0,0,0, 1,0,1,0, 2);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 1);
    @(negedge aclk);
    #1;
    arstn = 1'b0;
    #1;
    check("reset_async_outputs", 32'({clr, inc, busy, done}), 32'd0);
    release_reset();
    begin_job("postrst", 1, 1, 1);
    idle(2, 0);
    cyc(1,0,0, 0,0,0,0, 0);
    cyc(0,0,0, 1,0,1,0, 0);
    cyc(0,0,0, 0,0,1,0, 0);
    cyc(0,0,0, 0,1,1,0, 0);
    cyc(0,0,0, 0,0,1,0, 1);
    cyc(0,0,0, 0,0,0,1, 1);
    cyc(0,0,0, 0,0,0,0, 1);

    // target=2^WIDTH-1 stops at 255 without wrapping.
    begin_job("t255", 0, 255, 255);
    cyc(1,0,0, 0,0,0,0, 1);
    cyc(0,0,0, 1,0,1,0, 1);
    for (int i = 0; i < 255; i++) cyc(0,0,0, 0,1,1,0, i);
    cyc(0,0,0, 0,0,1,0, 255);
    cyc(0,0,0, 0,0,0,1, 255);
    idle(3, 255);

    @(posedge aclk);
    @(posedge aclk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("job_q_drained", 32'(job_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
